cr_sa_snap_sched: RTL and testbench

- Sequencer that drives the snapshot/clear controls of the 64-counter statistics aggregator core.
- Walks the latched snapshot array and streams every entry out as tagged 64-bit records on a valid/ready interface.
- Snapshots are triggered by a programmable periodic timer or a software pulse.
- Sits beside the aggregator regfile; it replaces the software-only snap path when periodic export is enabled.

---
 rtl/cr_sa_snap_sched_pkg.sv | 45 ++++
 rtl/cr_sa_snap_sched_if.sv | 20 ++
 rtl/cr_sa_snap_sched_timer.sv | 47 ++++
 rtl/cr_sa_snap_sched.sv | 179 +++++++++++++++++
 tb/tb_cr_sa_snap_sched.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cr_sa_snap_sched_pkg.sv
// ============================================================================
// Module : cr_sa_snap_sched_pkg
// Brief  : Shared types and constants for the snapshot export sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cr_sa_snap_sched_pkg;

  localparam int SA_REC_W   = 64;
  localparam int SA_IDX_W   = 6;
  localparam int SA_EPOCH_W = 8;
  localparam int SA_CNT_W   = 50;
  localparam int SA_N_MAX   = 64;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SNAP   = 3'd1,
    S_SETTLE = 3'd2,
    S_RD     = 3'd3,
    S_SEND   = 3'd4,
    S_DONE   = 3'd5
  } sa_sched_state_e;

  typedef struct packed {
    logic [SA_IDX_W-1:0]   idx;
    logic [SA_EPOCH_W-1:0] epoch;
    logic [SA_CNT_W-1:0]   count;
  } sa_rec_t;

  // Lowest unmasked index in [from, n); returns n when none is left.
  function automatic logic [SA_IDX_W:0] sa_next_idx(input logic [SA_N_MAX-1:0] mask,
                                                     input logic [SA_IDX_W:0]   from,
                                                     input int                  n);
    logic [SA_IDX_W:0] r;
    r = (SA_IDX_W+1)'(n);
    for (int i = SA_N_MAX - 1; i >= 0; i--) begin
      if (i < n && i >= int'(from) && !mask[i]) r = (SA_IDX_W+1)'(i);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cr_sa_snap_sched_if.sv
// ============================================================================
// Module : cr_sa_snap_sched_if
// Brief  : Record stream (valid/ready) carrying tagged 64-bit snapshot records.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cr_sa_snap_sched_if;
  import cr_sa_snap_sched_pkg::*;

  logic                rec_valid;
  logic                rec_ready;
  logic [SA_REC_W-1:0] rec_data;

  modport master (output rec_valid, output rec_data, input rec_ready);
  modport slave  (input rec_valid, input rec_data, output rec_ready);

endinterface

`default_nettype wire

// File: rtl/cr_sa_snap_sched_timer.sv
// ============================================================================
// Module : cr_sa_snap_timer
// Brief  : Periodic snapshot trigger; counts 0..period-1, held at 0 when idle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cr_sa_snap_timer #(
  parameter int PERIOD_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                trig_o
);

  logic [PERIOD_W-1:0] cnt_q;
  logic                trig_q;
  logic                w_run;
  logic                w_term;

  assign w_run  = enable_i && (period_i != '0);
  // >= so that shrinking the period below the running count still wraps promptly
  assign w_term = (cnt_q >= (period_i - PERIOD_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      trig_q <= 1'b0;
    end else if (!w_run) begin
      cnt_q  <= '0;
      trig_q <= 1'b0;
    end else if (w_term) begin
      cnt_q  <= '0;
      trig_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + PERIOD_W'(1);
      trig_q <= 1'b0;
    end
  end

  assign trig_o = trig_q;

endmodule

`default_nettype wire

// File: rtl/cr_sa_snap_sched.sv
// ============================================================================
// Module : cr_sa_snap_sched
// Brief  : Snapshot/clear sequencer streaming the aggregator snapshot array.
//          Optional skip mask enabled by CR_SA_SNAP_SCHED_MASK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cr_sa_snap_sched
  import cr_sa_snap_sched_pkg::*;
#(
  parameter int N_CNT    = 64,
  parameter int CNT_W    = 50,
  parameter int SETTLE   = 2,
  parameter int PERIOD_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_enable_i,
  input  logic [PERIOD_W-1:0]   cfg_period_i,
  input  logic                  cfg_clear_on_snap_i,
`ifdef CR_SA_SNAP_SCHED_MASK_EN
  input  logic [SA_N_MAX-1:0]   cfg_skip_mask_i,
`endif
  input  logic                  sw_snap_req_i,
  input  logic                  sw_clear_req_i,
  output logic                  sa_snap_o,
  output logic                  sa_clear_live_o,
  output logic [SA_IDX_W-1:0]   sa_rd_idx_o,
  input  logic [CNT_W-1:0]      sa_rd_data_i,
  cr_sa_snap_sched_if.master    rec_if,
  output logic                  busy_o,
  output logic [SA_EPOCH_W-1:0] epoch_o,
  output logic                  overrun_o
);

  localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  sa_sched_state_e       state_q;
  logic [SA_IDX_W-1:0]   idx_q;
  logic [SA_EPOCH_W-1:0] epoch_q;
  logic [SETTLE_W-1:0]   settle_q;
  logic                  busy_q, snap_q, clear_q, rec_valid_q, cap_q;
  sa_rec_t               rec_q;
  logic                  snap_pend_q, snap_pend_d;
  logic                  clr_pend_q, clr_pend_d;
  logic                  overrun_q, overrun_d;

  logic                  w_tmr_trig, w_trig, w_start, w_idle_clr, w_snap_clr;
  logic [SA_N_MAX-1:0]   w_mask;
  logic [SA_IDX_W:0]     w_first, w_next;
  sa_rec_t               w_live;

  cr_sa_snap_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (cfg_enable_i),
    .period_i (cfg_period_i),
    .trig_o   (w_tmr_trig)
  );

`ifdef CR_SA_SNAP_SCHED_MASK_EN
  logic [SA_N_MAX-1:0] mask_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mask_q <= '0;
    else if (w_start) mask_q <= cfg_skip_mask_i;
  end
  assign w_mask = mask_q;
`else
  assign w_mask = '0;
`endif

  assign w_trig     = cfg_enable_i && (w_tmr_trig || sw_snap_req_i);
  assign w_start    = (state_q == S_IDLE) && (snap_pend_q || w_trig);
  assign w_idle_clr = (state_q == S_IDLE) && !w_start && clr_pend_q;
  assign w_snap_clr = w_start && (cfg_clear_on_snap_i || clr_pend_q);
  assign w_first    = sa_next_idx(w_mask, '0, N_CNT);
  assign w_next     = sa_next_idx(w_mask, {1'b0, idx_q} + (SA_IDX_W+1)'(1), N_CNT);
  assign w_live     = '{idx: idx_q, epoch: epoch_q, count: sa_rd_data_i};

  // In IDLE a fresh trigger starts directly; elsewhere it parks in snap_pend.
  always_comb begin
    snap_pend_d = snap_pend_q;
    if (w_start)                   snap_pend_d = 1'b0;
    else if (w_trig)               snap_pend_d = 1'b1;
    overrun_d  = overrun_q || (w_trig && snap_pend_q);
    clr_pend_d = (clr_pend_q && !(w_idle_clr || w_snap_clr)) || sw_clear_req_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      epoch_q     <= '0;
      settle_q    <= '0;
      busy_q      <= 1'b0;
      snap_q      <= 1'b0;
      clear_q     <= 1'b0;
      rec_valid_q <= 1'b0;
      cap_q       <= 1'b0;
      rec_q       <= '0;
      snap_pend_q <= 1'b0;
      clr_pend_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      snap_pend_q <= snap_pend_d;
      clr_pend_q  <= clr_pend_d;
      overrun_q   <= overrun_d;
      snap_q      <= 1'b0;
      clear_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_start) begin
            state_q  <= S_SNAP;
            snap_q   <= 1'b1;
            clear_q  <= w_snap_clr;
            busy_q   <= 1'b1;
            idx_q    <= '0;
            settle_q <= '0;
          end else if (clr_pend_q) begin
            clear_q <= 1'b1;
          end
        end
        S_SNAP: state_q <= S_SETTLE;
        S_SETTLE: begin
          if (settle_q == SETTLE_W'(SETTLE - 1)) begin
            if (w_first == (SA_IDX_W+1)'(N_CNT)) begin
              state_q <= S_DONE;
            end else begin
              idx_q   <= w_first[SA_IDX_W-1:0];
              state_q <= S_RD;
            end
          end else begin
            settle_q <= settle_q + SETTLE_W'(1);
          end
        end
        S_RD: begin
          state_q     <= S_SEND;
          rec_valid_q <= 1'b1;
          cap_q       <= 1'b0;
        end
        S_SEND: begin
          // Read data arrives on the first SEND cycle and is frozen after it.
          if (rec_if.rec_ready) begin
            rec_valid_q <= 1'b0;
            cap_q       <= 1'b0;
            if (w_next == (SA_IDX_W+1)'(N_CNT)) begin
              state_q <= S_DONE;
            end else begin
              idx_q   <= w_next[SA_IDX_W-1:0];
              state_q <= S_RD;
            end
          end else if (!cap_q) begin
            cap_q <= 1'b1;
            rec_q <= w_live;
          end
        end
        S_DONE: begin
          epoch_q <= epoch_q + SA_EPOCH_W'(1);
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sa_snap_o       = snap_q;
  assign sa_clear_live_o = clear_q;
  assign sa_rd_idx_o     = idx_q;
  assign busy_o          = busy_q;
  assign epoch_o         = epoch_q;
  assign overrun_o       = overrun_q;
  assign rec_if.rec_valid = rec_valid_q;
  assign rec_if.rec_data  = !rec_valid_q ? '0 : (cap_q ? rec_q : w_live);

endmodule

`default_nettype wire

// File: tb/tb_cr_sa_snap_sched.sv
// ============================================================================
// Module : tb_cr_sa_snap_sched
// Brief  : Scoreboard bench for the snapshot export sequencer with a core model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cr_sa_snap_sched;
  import cr_sa_snap_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [31:0] cfg_period = '0;
  logic        cfg_clear_on_snap = 1'b0;
  logic        sw_snap_req = 1'b0;
  logic        sw_clear_req = 1'b0;
  logic        sa_snap, sa_clear_live, busy, overrun;
  logic [5:0]  sa_rd_idx;
  logic [49:0] sa_rd_data = '0;
  logic [7:0]  epoch;
`ifdef CR_SA_SNAP_SCHED_MASK_EN
  logic [63:0] cfg_skip_mask = '0;
`endif

  cr_sa_snap_sched_if rec_if ();

  cr_sa_snap_sched dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cfg_enable_i        (cfg_enable),
    .cfg_period_i        (cfg_period),
    .cfg_clear_on_snap_i (cfg_clear_on_snap),
`ifdef CR_SA_SNAP_SCHED_MASK_EN
    .cfg_skip_mask_i     (cfg_skip_mask),
`endif
    .sw_snap_req_i       (sw_snap_req),
    .sw_clear_req_i      (sw_clear_req),
    .sa_snap_o           (sa_snap),
    .sa_clear_live_o     (sa_clear_live),
    .sa_rd_idx_o         (sa_rd_idx),
    .sa_rd_data_i        (sa_rd_data),
    .rec_if              (rec_if),
    .busy_o              (busy),
    .epoch_o             (epoch),
    .overrun_o           (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  logic [63:0] exp_q[$];

  // Core model: live counter i reads {i, cycle}; snapshot latched on sa_snap.
  logic [49:0] snap_arr [64];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sa_snap) for (int i = 0; i < 64; i++) snap_arr[i] <= {6'(i), 44'(cyc)};
    sa_rd_data <= snap_arr[sa_rd_idx];
  end

  // Monitor: pop on every handshake, and require stability while stalled.
  logic        prev_hold = 1'b0;
  logic [63:0] prev_data = '0;
  logic [63:0] mon_exp;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold) begin
        checks++;
        if (!rec_if.rec_valid || rec_if.rec_data !== prev_data) begin
          errors++;
          $display("FAIL rec_hold: got valid=%0b data=%0h, expected valid=1 data=%0h",
                   rec_if.rec_valid, rec_if.rec_data, prev_data);
        end
      end
      if (rec_if.rec_valid && rec_if.rec_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rec_extra: got %0h, expected no record", rec_if.rec_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (rec_if.rec_data !== mon_exp) begin
            errors++;
            $display("FAIL rec_data: got %0h, expected %0h", rec_if.rec_data, mon_exp);
          end
        end
      end
      prev_hold = rec_if.rec_valid && !rec_if.rec_ready;
      prev_data = rec_if.rec_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  int clr_idle_cnt = 0;
  int clr_busy_bad = 0;
  always @(negedge clk) begin
    if (rst_n && sa_clear_live) begin
      if (!busy)         clr_idle_cnt++;
      else if (!sa_snap) clr_busy_bad++;
    end
  end

  bit rand_rdy = 1'b0;
  always @(posedge clk) begin
    #2;
    if (rand_rdy) rec_if.rec_ready = ($urandom_range(0, 99) >= 30);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_seq(input logic [7:0] ep, input int unsigned sc,
                                   input logic [63:0] mask);
    for (int i = 0; i < 64; i++)
      if (!mask[i]) exp_q.push_back({6'(i), ep, 6'(i), 44'(sc)});
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle: got busy=1 after %0d cycles, expected 0", budget);
    end
  endtask

  task automatic wait_rec_idx(input logic [5:0] want, input int budget);
    int n = 0;
    @(negedge clk);
    while (!(rec_if.rec_valid && rec_if.rec_data[63:58] == want) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(rec_if.rec_valid && rec_if.rec_data[63:58] == want)) begin
      errors++;
      $display("FAIL wait_rec_idx: got timeout, expected idx %0d valid", want);
    end
  endtask

  // Issue a one-cycle software request; returns the issue cycle, checks sa_snap next cycle.
  task automatic sw_snap_run(output int unsigned t);
    sw_snap_req = 1'b1;
    t = cyc;
    tick();
    sw_snap_req = 1'b0;
    check("sa_snap_latency", 64'(sa_snap), 64'd1);
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) tick();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  ep;
    int unsigned t, e, r;
    rec_if.rec_ready = 1'b1;
    repeat (3) tick();
    check("rst_sa_snap",  64'(sa_snap), 0);
    check("rst_clear",    64'(sa_clear_live), 0);
    check("rst_rec_valid", 64'(rec_if.rec_valid), 0);
    check("rst_rec_data", rec_if.rec_data, 0);
    check("rst_busy",     64'(busy), 0);
    check("rst_epoch",    64'(epoch), 0);
    check("rst_overrun",  64'(overrun), 0);
    check("rst_rd_idx",   64'(sa_rd_idx), 0);
    rst_n = 1'b1;
    cfg_enable = 1'b1;
    repeat (5) tick();

    // Software snapshot, full-rate ready
    ep = 8'd0;
    sw_snap_run(t);
    push_seq(ep, t + 1, '0);
    wait_idle(400);
    ep++;
    check("epoch_after_first", 64'(epoch), 64'(ep));
    check("overrun_first", 64'(overrun), 0);
    check("sb_empty_first", 64'(exp_q.size()), 0);

    // Clear request mid-stream waits until the sequence ends
    clr_idle_cnt = 0;
    sw_snap_run(t);
    push_seq(ep, t + 1, '0);
    wait_rec_idx(6'd20, 200);
    sw_clear_req = 1'b1;
    tick();
    sw_clear_req = 1'b0;
    check("clr_not_early", 64'(clr_idle_cnt), 0);
    wait_idle(400);
    ep++;
    repeat (5) tick();
    check("clr_idle_pulse", 64'(clr_idle_cnt), 1);
    check("clr_busy_bad", 64'(clr_busy_bad), 0);

    // Clear-on-snap coincides with sa_snap
    cfg_clear_on_snap = 1'b1;
    sw_snap_run(t);
    check("clear_with_snap", 64'(sa_clear_live), 1);
    cfg_clear_on_snap = 1'b0;
    push_seq(ep, t + 1, '0);
    wait_idle(400);
    ep++;

    // Timer trigger with stalled sink: one pends, later ones overrun
    rec_if.rec_ready = 1'b0;
    cfg_period = 32'd50;
    e = cyc;
    push_seq(ep, e + 51, '0);
    wait_cyc(e + 51);
    check("timer_snap", 64'(sa_snap), 1);
    wait_cyc(e + 120);
    check("overrun_pend_only", 64'(overrun), 0);
    wait_cyc(e + 160);
    check("overrun_set", 64'(overrun), 1);
    wait_cyc(e + 290);
    r = cyc;
    cfg_enable = 1'b0;
    cfg_period = '0;
    rec_if.rec_ready = 1'b1;
    ep++;
    push_seq(ep, r + 129, '0);
    wait_cyc(r + 129);
    check("pending_snap", 64'(sa_snap), 1);
    rand_rdy = 1'b1;
    wait_idle(1200);
    rand_rdy = 1'b0;
    rec_if.rec_ready = 1'b1;
    ep++;
    check("overrun_sticky", 64'(overrun), 1);
    check("sb_empty_bp", 64'(exp_q.size()), 0);
    check("epoch_bp", 64'(epoch), 64'(ep));

    // Asynchronous reset mid-stream abandons the sequence
    cfg_enable = 1'b1;
    sw_snap_run(t);
    push_seq(ep, t + 1, '0);
    wait_rec_idx(6'd37, 200);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_valid",   64'(rec_if.rec_valid), 0);
    check("mrst_busy",    64'(busy), 0);
    check("mrst_epoch",   64'(epoch), 0);
    check("mrst_overrun", 64'(overrun), 0);
    check("mrst_rd_idx",  64'(sa_rd_idx), 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    ep = 8'd0;

`ifdef CR_SA_SNAP_SCHED_MASK_EN
    cfg_skip_mask = 64'hFFFF_FFFF_FFFF_FFFE;
    sw_snap_run(t);
    push_seq(ep, t + 1, cfg_skip_mask);
    wait_idle(100);
    cfg_skip_mask = '0;
    ep++;
    check("mask_sb_empty", 64'(exp_q.size()), 0);
`endif

    // 256 back-to-back sequences: epoch wraps to its starting value
    for (int k = 0; k < 256; k++) begin
      sw_snap_run(t);
      push_seq(ep, t + 1, '0);
      wait_idle(400);
      ep++;
      check("epoch_step", 64'(epoch), 64'(ep));
    end
    check("sb_empty_end", 64'(exp_q.size()), 0);
    check("clr_busy_end", 64'(clr_busy_bad), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
